cache_response_collector: RTL and testbench
===========================================

Name: cache_response_collector

Overview:
- Sits directly downstream of the cache access arbiter.
- Captures read-return beats (readReady / requesterAddressOut / cacheDataOut) presented on the four directional ports.
- Queues them in one shared FIFO and drains them one per cycle to the router injection port over a valid/ready handshake.
- Provides the back-pressure signal (stall) that the arbiter's issue logic uses to hold off new reads.

Parameters:
- DATA_WIDTH, 32, width of one cache data word.
- NETWORK_ADDRESS_WIDTH, 8, width of a requester network address.
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- STALL_THRESHOLD, 4, stall asserts when free entries < STALL_THRESHOLD.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- readReady_NORTH/SOUTH/EAST/WEST  in  1 each  read-return beat valid on that port this cycle.
- requesterAddressIn_NORTH/SOUTH/EAST/WEST  in  NETWORK_ADDRESS_WIDTH each  destination of the returned word.
- cacheDataIn_NORTH/SOUTH/EAST/WEST  in  DATA_WIDTH each  returned word.
- respValid  out  1  head entry available.
- respReady  in  1  consumer accepts the head this cycle.
- respData  out  DATA_WIDTH  head word.
- respDestAddress  out  NETWORK_ADDRESS_WIDTH  head requester address.
- respSourcePort  out  2  head origin port: 0=N, 1=S, 2=E, 3=W.
- stall  out  1  registered; asserted when free entries < STALL_THRESHOLD.
- overflow  out  1  sticky; set when any beat is dropped.
- occupancy  out  log2(DEPTH)+1  current entry count.

Behaviour:
- Reset (reset low, asynchronous):
  - Clears write/read pointers, occupancy, stall, overflow and all storage.
  - respValid=0, respData=0, respDestAddress=0, respSourcePort=0.
  - Deassertion is sampled synchronously: first push possible on the first rising edge with reset high.
- Push:
  - Each rising edge, every port with readReady high is a request.
  - Requests are written in fixed priority order N, S, E, W into consecutive slots starting at wrPtr.
  - Up to 4 pushes per cycle; wrPtr advances by the number accepted, modulo DEPTH (wraps naturally).
- Pop:
  - Occurs when respValid && respReady at the rising edge.
  - rdPtr advances by 1 modulo DEPTH.
  - respReady while respValid=0 is ignored.
- Output path:
  - respValid = (occupancy != 0).
  - respData, respDestAddress, respSourcePort are driven from the entry at rdPtr, read from the registered storage array.
  - Outputs are held stable while respValid && !respReady.
  - When empty, data outputs hold 0.
- Latency: a beat pushed into an empty FIFO at edge N appears on the outputs with respValid=1 after edge N. Minimum latency is 1 cycle; there is no fall-through.
- Capacity:
  - free = DEPTH - occupancy, evaluated before this cycle's pop.
  - A same-cycle pop does not create room for same-cycle pushes.
  - If requests exceed free, the first "free" requests in priority order are accepted and the rest dropped.
  - overflow is set on the next edge and stays set until reset.
- Occupancy: next = occupancy + accepted - pop; never exceeds DEPTH and never goes below 0.
- stall:
  - Registered from next occupancy: stall <= (DEPTH - next occupancy) < STALL_THRESHOLD.
  - The arbiter issues at most 2 reads per cycle with 1-cycle return, so this threshold prevents drops when the arbiter honours stall.
- Simultaneous push and pop with occupancy=DEPTH: pop completes, pushes are dropped, overflow sets, occupancy becomes DEPTH-1.
- Reset asserted mid-operation: all queued entries are discarded immediately and no partial pop completes.

Optional Feature:
- Macro: CACHE_RESP_AGE_EN.
- When defined:
  - A 16-bit free-running cycle counter (reset to 0, wraps) is added.
  - Each entry stores the counter value at push.
  - Extra output respAge (16 bits) = counter - stored stamp, modulo 2^16, for the head entry; 0 when empty.
- When undefined: no counter, no stamp storage, and the respAge port is absent.

Test Plan:
- Reset then single push: readReady_EAST=1, addr=0x12, data=0xDEADBEEF at edge 1, respReady=0 → after edge 1 respValid=1, respData=0xDEADBEEF, respDestAddress=0x12, respSourcePort=2, occupancy=1.
- Ordering: N=0x1, S=0x2, E=0x3, W=0x4 in one cycle, then respReady=1 held → outputs 0x1, 0x2, 0x3, 0x4 on four consecutive cycles, then respValid=0, occupancy=0.
- Full/overflow with DEPTH=8: push 4 entries on each of 2 cycles, then N and S on the third cycle with respReady=0 → both dropped, overflow=1, occupancy=8, stall=1 from the cycle after the second push.
- Wrap-around: 20 single pushes interleaved with pops at respReady=1 → the data sequence out matches the sequence in, no drops, overflow=0.
- Async reset mid-stream: occupancy=5, pull reset low between edges → respValid, occupancy, stall immediately 0; after release the next push appears alone at the head.
- CACHE_RESP_AGE_EN: push at counter=100, hold respReady=0 for 7 edges → respAge=7; then pop → respAge=0 when empty.

Source files
------------

// File: rtl/cache_response_collector_if.sv
// cache_response_collector_if: read-return beats from the four cache ports plus the drained response stream and status.
// respAge exists only when CACHE_RESP_AGE_EN is defined.
interface cache_response_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NETWORK_ADDRESS_WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int OW = $clog2(DEPTH) + 1;
    logic readReady_NORTH, readReady_SOUTH, readReady_EAST, readReady_WEST;
    logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn_NORTH, requesterAddressIn_SOUTH;
    logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn_EAST, requesterAddressIn_WEST;
    logic [DATA_WIDTH-1:0] cacheDataIn_NORTH, cacheDataIn_SOUTH, cacheDataIn_EAST, cacheDataIn_WEST;
    logic respValid;
    logic respReady;
    logic [DATA_WIDTH-1:0] respData;
    logic [NETWORK_ADDRESS_WIDTH-1:0] respDestAddress;
    logic [1:0] respSourcePort;
    logic stall;
    logic overflow;
    logic [OW-1:0] occupancy;
`ifdef CACHE_RESP_AGE_EN
    logic [15:0] respAge;
`endif
    modport master (
        output readReady_NORTH, readReady_SOUTH, readReady_EAST, readReady_WEST,
        output requesterAddressIn_NORTH, requesterAddressIn_SOUTH, requesterAddressIn_EAST, requesterAddressIn_WEST,
        output cacheDataIn_NORTH, cacheDataIn_SOUTH, cacheDataIn_EAST, cacheDataIn_WEST,
        output respReady,
        input respValid, respData, respDestAddress, respSourcePort, stall, overflow, occupancy
`ifdef CACHE_RESP_AGE_EN
        , input respAge
`endif
    );
    modport slave (
        input readReady_NORTH, readReady_SOUTH, readReady_EAST, readReady_WEST,
        input requesterAddressIn_NORTH, requesterAddressIn_SOUTH, requesterAddressIn_EAST, requesterAddressIn_WEST,
        input cacheDataIn_NORTH, cacheDataIn_SOUTH, cacheDataIn_EAST, cacheDataIn_WEST,
        input respReady,
        output respValid, respData, respDestAddress, respSourcePort, stall, overflow, occupancy
`ifdef CACHE_RESP_AGE_EN
        , output respAge
`endif
    );
endinterface

// File: rtl/cache_response_collector.sv
// cache_response_collector: packs up to four read-return beats per cycle into a shared FIFO and drains one per cycle.
// Define CACHE_RESP_AGE_EN to add a 16-bit per-entry age output (respAge).
module cache_response_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int NETWORK_ADDRESS_WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int STALL_THRESHOLD = 4
) (
    input logic clk,
    input logic reset,
    cache_response_collector_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    logic [3:0] req, acc;
    logic [DATA_WIDTH-1:0] req_data [4];
    logic [NETWORK_ADDRESS_WIDTH-1:0] req_addr [4];
    logic [PW-1:0] slot [4];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [NETWORK_ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [1:0] port_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, occ_d, free, cnt;
    logic pop, drop, stall_q, stall_d, overflow_q;

    assign req = {bus.readReady_WEST, bus.readReady_EAST, bus.readReady_SOUTH, bus.readReady_NORTH};
    assign req_data = '{bus.cacheDataIn_NORTH, bus.cacheDataIn_SOUTH, bus.cacheDataIn_EAST, bus.cacheDataIn_WEST};
    assign req_addr = '{bus.requesterAddressIn_NORTH, bus.requesterAddressIn_SOUTH,
                        bus.requesterAddressIn_EAST, bus.requesterAddressIn_WEST};

    // Room is judged before this cycle's pop, so a pop never frees a slot for a same-cycle push.
    always_comb begin
        free = OW'(DEPTH) - occ_q;
        cnt = '0;
        for (int i = 0; i < 4; i++) begin
            acc[i] = req[i] && (cnt < free);
            slot[i] = wr_ptr_q + cnt[PW-1:0];
            cnt = cnt + OW'(acc[i]);
        end
        drop = |(req & ~acc);
        pop = bus.respValid && bus.respReady;
        occ_d = occ_q + cnt - OW'(pop);
        stall_d = (DEPTH - int'(occ_d)) < STALL_THRESHOLD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q <= '0;
            stall_q <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
                port_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    data_q[slot[i]] <= req_data[i];
                    addr_q[slot[i]] <= req_addr[i];
                    port_q[slot[i]] <= 2'(i);
                end
            end
            wr_ptr_q <= wr_ptr_q + cnt[PW-1:0];
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            occ_q <= occ_d;
            stall_q <= stall_d;
            overflow_q <= overflow_q | drop;
        end
    end

    assign bus.respValid = occ_q != '0;
    assign bus.respData = bus.respValid ? data_q[rd_ptr_q] : '0;
    assign bus.respDestAddress = bus.respValid ? addr_q[rd_ptr_q] : '0;
    assign bus.respSourcePort = bus.respValid ? port_q[rd_ptr_q] : '0;
    assign bus.stall = stall_q;
    assign bus.overflow = overflow_q;
    assign bus.occupancy = occ_q;

`ifdef CACHE_RESP_AGE_EN
    logic [15:0] cyc_q;
    logic [15:0] stamp_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            for (int i = 0; i < DEPTH; i++) stamp_q[i] <= '0;
        end else begin
            cyc_q <= cyc_q + 16'd1;
            for (int i = 0; i < 4; i++) if (acc[i]) stamp_q[slot[i]] <= cyc_q;
        end
    end

    assign bus.respAge = bus.respValid ? cyc_q - stamp_q[rd_ptr_q] : '0;
`endif
endmodule

// File: tb/tb_cache_response_collector.sv
// tb_cache_response_collector: queue-based reference model checked every cycle, plus directed literal checks.
module tb_cache_response_collector;
    localparam int DEPTH = 8;
    localparam int THR = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] rr;
    logic [7:0] ad [4];
    logic [31:0] dd [4];
    logic rdy;
    int n_checks = 0;
    int n_fail = 0;

    cache_response_collector_if #(.DATA_WIDTH(32), .NETWORK_ADDRESS_WIDTH(8), .DEPTH(DEPTH)) bus ();
    cache_response_collector #(.DATA_WIDTH(32), .NETWORK_ADDRESS_WIDTH(8), .DEPTH(DEPTH), .STALL_THRESHOLD(THR))
        dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.readReady_NORTH = rr[0];
    assign bus.readReady_SOUTH = rr[1];
    assign bus.readReady_EAST = rr[2];
    assign bus.readReady_WEST = rr[3];
    assign bus.requesterAddressIn_NORTH = ad[0];
    assign bus.requesterAddressIn_SOUTH = ad[1];
    assign bus.requesterAddressIn_EAST = ad[2];
    assign bus.requesterAddressIn_WEST = ad[3];
    assign bus.cacheDataIn_NORTH = dd[0];
    assign bus.cacheDataIn_SOUTH = dd[1];
    assign bus.cacheDataIn_EAST = dd[2];
    assign bus.cacheDataIn_WEST = dd[3];
    assign bus.respReady = rdy;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0] a;
        logic [1:0] p;
        logic [15:0] s;
    } ent_t;
    ent_t mq[$];
    ent_t e;
    logic m_ovf, m_stall, pop_m;
    logic [15:0] m_cyc;
    int free_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: FIFO of beats; room counted before the pop, overflow sticky.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_stall = 1'b0;
            m_cyc = '0;
        end else begin
            free_m = DEPTH - mq.size();
            pop_m = (mq.size() != 0) && rdy;
            if (pop_m) void'(mq.pop_front());
            for (int i = 0; i < 4; i++) begin
                if (rr[i]) begin
                    if (free_m > 0) begin
                        e.d = dd[i];
                        e.a = ad[i];
                        e.p = 2'(i);
                        e.s = m_cyc;
                        mq.push_back(e);
                        free_m--;
                    end else m_ovf = 1'b1;
                end
            end
            m_stall = (DEPTH - mq.size()) < THR;
            m_cyc = m_cyc + 16'd1;
        end
    end

    always @(negedge clk) begin
        chk("m_valid", bus.respValid, mq.size() != 0);
        chk("m_data", bus.respData, mq.size() != 0 ? mq[0].d : 32'd0);
        chk("m_addr", bus.respDestAddress, mq.size() != 0 ? mq[0].a : 8'd0);
        chk("m_port", bus.respSourcePort, mq.size() != 0 ? mq[0].p : 2'd0);
        chk("m_occ", bus.occupancy, mq.size());
        chk("m_stall", bus.stall, m_stall);
        chk("m_ovf", bus.overflow, m_ovf);
`ifdef CACHE_RESP_AGE_EN
        chk("m_age", bus.respAge, mq.size() != 0 ? 16'(m_cyc - mq[0].s) : 16'd0);
`endif
    end

    task automatic idle();
        rr = '0;
        for (int i = 0; i < 4; i++) begin
            ad[i] = '0;
            dd[i] = '0;
        end
    endtask

    task automatic beat(input int p, input logic [7:0] a, input logic [31:0] d);
        rr[p] = 1'b1;
        ad[p] = a;
        dd[p] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_tick();
        tick();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        rdy = 1'b0;
        idle();
        repeat (2) tick();
        chk("rst_valid", bus.respValid, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_data", bus.respData, 0);
        reset = 1'b1;
        beat(2, 8'h12, 32'hDEADBEEF);
        push_tick();
        chk("single_valid", bus.respValid, 1);
        chk("single_data", bus.respData, 32'hDEADBEEF);
        chk("single_addr", bus.respDestAddress, 8'h12);
        chk("single_port", bus.respSourcePort, 2);
        chk("single_occ", bus.occupancy, 1);
        do_reset();
        for (int i = 0; i < 4; i++) beat(i, 8'(i + 1), 32'(i + 1));
        push_tick();
        chk("order_0", bus.respData, 1);
        rdy = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("order_n", bus.respData, i);
            chk("order_port", bus.respSourcePort, i - 1);
        end
        tick();
        chk("order_empty", bus.respValid, 0);
        chk("order_occ", bus.occupancy, 0);
        rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) beat(i, 8'h40, 32'h10 + 32'(i));
        push_tick();
        chk("full_occ4", bus.occupancy, 4);
        chk("full_stall4", bus.stall, 0);
        for (int i = 0; i < 4; i++) beat(i, 8'h50, 32'h20 + 32'(i));
        push_tick();
        chk("full_occ8", bus.occupancy, 8);
        chk("full_stall8", bus.stall, 1);
        chk("full_noovf", bus.overflow, 0);
        beat(0, 8'h60, 32'h30);
        beat(1, 8'h61, 32'h31);
        push_tick();
        chk("full_ovf", bus.overflow, 1);
        chk("full_occ", bus.occupancy, 8);
        chk("full_head", bus.respData, 32'h10);
        rdy = 1'b1;
        beat(0, 8'h70, 32'h70);
        push_tick();
        chk("fullpp_occ", bus.occupancy, 7);
        chk("fullpp_head", bus.respData, 32'h11);
        chk("fullpp_ovf", bus.overflow, 1);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            beat(i % 4, 8'(i), 32'h100 + 32'(i));
            push_tick();
            chk("wrap_head", bus.respData, 32'h100 + 32'(i));
        end
        tick();
        chk("wrap_occ", bus.occupancy, 0);
        chk("wrap_ovf", bus.overflow, 0);
        rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) beat(i, 8'h80, 32'h80 + 32'(i));
        push_tick();
        beat(0, 8'h84, 32'h84);
        push_tick();
        chk("ar_occ5", bus.occupancy, 5);
        chk("ar_stall5", bus.stall, 1);
        #1 reset = 1'b0;
        #1;
        chk("ar_valid", bus.respValid, 0);
        chk("ar_occ", bus.occupancy, 0);
        chk("ar_stall", bus.stall, 0);
        #2 reset = 1'b1;
        beat(3, 8'h33, 32'hABC);
        push_tick();
        chk("ar_post_occ", bus.occupancy, 1);
        chk("ar_post_data", bus.respData, 32'hABC);
        chk("ar_post_port", bus.respSourcePort, 3);
`ifdef CACHE_RESP_AGE_EN
        do_reset();
        repeat (100) tick();
        beat(0, 8'h01, 32'h5A5A);
        push_tick();
        repeat (6) tick();
        chk("age_7", bus.respAge, 7);
        rdy = 1'b1;
        tick();
        chk("age_empty", bus.respAge, 0);
        rdy = 1'b0;
`endif
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
